c2h_credit_sched: RTL
=====================

Name: c2h_credit_sched

Overview:
- Per-queue descriptor-credit tracker and round-robin scheduler for the C2H stream traffic generator.
- Consumes QDMA tm_dsc_sts descriptor-availability updates and keeps a saturating credit count per queue.
- Offers the next eligible queue ID to the packet datapath; a queue is eligible when it holds at least one packet's worth of credits.
- Deducts those credits when the datapath accepts the offer. Sits between the QDMA traffic-manager status port and traffic_gen.

Parameters:
- NUM_Q_MAX, 16, number of queue credit entries tracked (power of 2).
- QID_W, 11, QDMA queue ID width.
- CRDT_W, 16, credit counter width.

Ports:
- axi_aclk  in  1  clock.
- axi_aresetn  in  1  asynchronous active-low reset.
- enable  in  1  scheduler run enable.
- qid_base  in  QID_W  first QDMA queue of the window.
- num_queue  in  QID_W  number of queues in the window.
- crd_per_pkt  in  CRDT_W  descriptors consumed per packet.
- tm_dsc_sts_vld  in  1  status update valid.
- tm_dsc_sts_qid  in  QID_W  queue of the update.
- tm_dsc_sts_avl  in  16  newly available descriptors.
- tm_dsc_sts_qen  in  1  queue enabled.
- tm_dsc_sts_qinv  in  1  queue invalidated.
- tm_dsc_sts_dir  in  1  1 = C2H.
- tm_dsc_sts_mm  in  1  1 = memory-mapped.
- tm_dsc_sts_error  in  1  error flag.
- tm_dsc_sts_rdy  out  1  update accept.
- sched_valid  out  1  queue offer valid.
- sched_qid  out  QID_W  offered queue (qid_base + index).
- sched_ready  in  1  datapath accepts offer.
- pkt_sent_cnt  out  32  accepted offers.
- dsc_drop_cnt  out  16  ignored status updates.

Behaviour:
- Reset values: all credits 0, tm_dsc_sts_rdy 0, sched_valid 0, sched_qid 0, counters 0, rr_ptr 0, state IDLE.
- tm_dsc_sts_rdy: registered. It is 1 from the first clock edge after reset release onward.
- Update acceptance: on vld & rdy, with dir=1, mm=0, error=0, and (qid - qid_base) < eff_nq:
  - qinv=1: credit[idx] <= 0. qinv takes priority over qen.
  - else qen=1: credit[idx] <= min(credit + avl, 2^CRDT_W - 1).
  - else qen=0: no change.
- Dropped updates: every other accepted update increments dsc_drop_cnt. The counter saturates at 0xFFFF.
- Update latency: credit written at edge N is visible to the scheduler at N+1.
- eff_nq = min(num_queue, NUM_Q_MAX). qid_base and eff_nq are latched on the enable rising edge (IDLE->SCAN), and rr_ptr is cleared to 0 at the same edge. Changes to these inputs while running are ignored.
- FSM states:
  - IDLE: leave on enable=1 to SCAN.
  - SCAN: examines one queue per cycle.
    - enable=0: go to IDLE.
    - eff_nq=0 or crd_per_pkt=0: stay in SCAN, never offer.
    - credit[rr_ptr] >= crd_per_pkt: go to OFFER; sched_qid <= qid_base + rr_ptr; sched_valid <= 1.
    - otherwise: rr_ptr <= (rr_ptr + 1 == eff_nq) ? 0 : rr_ptr + 1.
  - OFFER: sched_valid and sched_qid held stable until sched_ready=1, even if enable drops.
    - On the handshake: credit[rr_ptr] -= crd_per_pkt; pkt_sent_cnt++ (wraps); rr_ptr advances with wrap; sched_valid <= 0.
    - Next state: SCAN if enable=1, else IDLE.
- Throughput: at most one offer per 2 cycles.
- Worst-case offer latency after credit arrival: eff_nq + 1 cycles.
- Simultaneous accepted update and handshake on the same queue: result = sat(credit + avl) - crd_per_pkt. With qinv, the result is 0.
- Credit never underflows, because an offer is only made when credit >= crd_per_pkt, and credit can only increase or be zeroed between offer and accept.
- Zeroed-credit offer: if qinv zeroes the offered queue during OFFER, the offer still completes and the deduct saturates at 0.
- Reset mid-operation: asynchronous; all state returns to reset values immediately. Any pending offer is dropped.

Decomposition:
- Package c2h_sched_pkg: CRDT_W and QID_W constants; sched_state_e typedef {IDLE, SCAN, OFFER}; sat_add function.
- Sub-module c2h_credit_table: NUM_Q_MAX×CRDT_W register array with one update port (sat add / clear) and one deduct port, with a combined same-index path; registered read by index.
- The FSM, window latch and counters live in the top level.

Test Plan:
- Reset, num_queue=4, crd_per_pkt=2, sched_ready=1, no updates -> sched_valid stays 0; tm_dsc_sts_rdy=1 one cycle after reset release.
- avl=4 to qid 0..3, enable=1, sched_ready=1 -> offers qid 0,1,2,3,0,1,2,3, one every 2 cycles; then none; pkt_sent_cnt=8.
- qid_base=8, update qid 5 and qid 12 (num_queue=4), plus update with mm=1 -> all ignored, dsc_drop_cnt=3, no offer.
- avl=0xFFFF twice to qid 0, then qinv=1 -> credit saturates at 0xFFFF, then 0; no offer after qinv.
- Offer qid 1 (credit 2, crd_per_pkt=2), hold sched_ready=0 for 10 cycles while enable drops -> sched_valid/sched_qid stable; on ready, credit 0, state IDLE.
- Random LFSR sched_ready and random avl to 4 queues for 100k cycles -> scoreboard: per-queue offers×crd_per_pkt <= total credits granted, and offers are strict round-robin among eligible queues.

Source files
------------

// File: rtl/c2h_sched_pkg.sv
// Shared constants, FSM state type and saturating-add helper for the C2H
// credit scheduler.
package c2h_sched_pkg;

    localparam int QID_W  = 11;
    localparam int CRDT_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        OFFER = 2'd2
    } sched_state_e;

    // Width-agnostic saturating add; callers cast operands up and the result down.
    function automatic logic [31:0] sat_add(
        input logic [31:0] a,
        input logic [31:0] b,
        input logic [31:0] max_val
    );
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return (sum > {1'b0, max_val}) ? max_val : sum[31:0];
    endfunction

endpackage

// File: rtl/c2h_credit_table.sv
// Per-queue credit registers: one update port (saturating add or clear), one
// deduct port, both allowed on the same entry in one cycle; read by index.
module c2h_credit_table #(
    parameter int NUM_Q_MAX = 16,
    parameter int CRDT_W    = 16,
    parameter int IDX_W     = $clog2(NUM_Q_MAX)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              upd_en,
    input  logic [IDX_W-1:0]  upd_idx,
    input  logic              upd_clr,
    input  logic [15:0]       upd_avl,
    input  logic              ded_en,
    input  logic [IDX_W-1:0]  ded_idx,
    input  logic [CRDT_W-1:0] ded_amt,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [CRDT_W-1:0] rd_credit
);
    import c2h_sched_pkg::*;

    localparam logic [31:0] CRDT_MAX = 32'((64'd1 << CRDT_W) - 64'd1);

    logic [CRDT_W-1:0] credit_q [NUM_Q_MAX];
    logic [CRDT_W-1:0] credit_d [NUM_Q_MAX];

    // Update is applied first and the deduct acts on its result, so a same-entry
    // collision yields sat(credit + avl) - amt, or 0 after a clear.
    always_comb begin
        for (int i = 0; i < NUM_Q_MAX; i++) begin
            credit_d[i] = credit_q[i];
            if (upd_en && upd_idx == IDX_W'(i)) begin
                if (upd_clr) begin
                    credit_d[i] = '0;
                end else begin
                    credit_d[i] = CRDT_W'(sat_add(32'(credit_q[i]), 32'(upd_avl), CRDT_MAX));
                end
            end
            if (ded_en && ded_idx == IDX_W'(i)) begin
                credit_d[i] = (credit_d[i] >= ded_amt) ? credit_d[i] - ded_amt : '0;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NUM_Q_MAX; i++) begin
                credit_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_Q_MAX; i++) begin
                credit_q[i] <= credit_d[i];
            end
        end
    end

    assign rd_credit = credit_q[rd_idx];

endmodule

// File: rtl/c2h_credit_sched.sv
// Descriptor-credit tracker and round-robin queue scheduler feeding traffic_gen.
// Offer handshake: sched_valid/sched_qid stay fixed until sched_ready is seen high at a clock edge; that edge transfers the offer.
module c2h_credit_sched #(
    parameter int NUM_Q_MAX = 16,
    parameter int QID_W     = c2h_sched_pkg::QID_W,
    parameter int CRDT_W    = c2h_sched_pkg::CRDT_W
) (
    input  logic                        axi_aclk,
    input  logic                        axi_aresetn,
    input  logic                        enable,
    input  logic [QID_W-1:0]            qid_base,
    input  logic [QID_W-1:0]            num_queue,
    input  logic [CRDT_W-1:0]           crd_per_pkt,
    input  logic                        tm_dsc_sts_vld,
    input  logic [QID_W-1:0]            tm_dsc_sts_qid,
    input  logic [15:0]                 tm_dsc_sts_avl,
    input  logic                        tm_dsc_sts_qen,
    input  logic                        tm_dsc_sts_qinv,
    input  logic                        tm_dsc_sts_dir,
    input  logic                        tm_dsc_sts_mm,
    input  logic                        tm_dsc_sts_error,
    output logic                        tm_dsc_sts_rdy,
    output logic                        sched_valid,
    output logic [QID_W-1:0]            sched_qid,
    input  logic                        sched_ready,
    output logic [31:0]                 pkt_sent_cnt,
    output logic [15:0]                 dsc_drop_cnt,
    output c2h_sched_pkg::sched_state_e dbg_state
);
    import c2h_sched_pkg::*;

    localparam int IDX_W = $clog2(NUM_Q_MAX);
    localparam int NQ_W  = IDX_W + 1;

    sched_state_e      state;
    logic [QID_W-1:0]  base_r;
    logic [NQ_W-1:0]   nq_r;
    logic [IDX_W-1:0]  rr_ptr;
    logic [IDX_W-1:0]  rr_next;
    logic [NQ_W-1:0]   eff_nq;
    logic [CRDT_W-1:0] rd_credit;

    logic [QID_W-1:0]  upd_off;
    logic              upd_acc;
    logic              upd_ok;
    logic              upd_en;
    logic              ded_en;

    assign eff_nq = (num_queue >= QID_W'(NUM_Q_MAX)) ? NQ_W'(NUM_Q_MAX) : NQ_W'(num_queue);

    // Window check uses the latched base/size; the subtraction wraps, so queues
    // below the base land far outside the window.
    assign upd_off = tm_dsc_sts_qid - base_r;
    assign upd_acc = tm_dsc_sts_vld & tm_dsc_sts_rdy;
    assign upd_ok  = upd_acc & tm_dsc_sts_dir & ~tm_dsc_sts_mm & ~tm_dsc_sts_error
                   & (upd_off < QID_W'(nq_r));
    assign upd_en  = upd_ok & (tm_dsc_sts_qinv | tm_dsc_sts_qen);
    assign ded_en  = (state == OFFER) & sched_ready;

    assign rr_next = (NQ_W'(rr_ptr) + NQ_W'(1) == nq_r) ? '0 : rr_ptr + IDX_W'(1);

    c2h_credit_table #(
        .NUM_Q_MAX (NUM_Q_MAX),
        .CRDT_W    (CRDT_W),
        .IDX_W     (IDX_W)
    ) u_credit_table (
        .clk       (axi_aclk),
        .resetn    (axi_aresetn),
        .upd_en    (upd_en),
        .upd_idx   (upd_off[IDX_W-1:0]),
        .upd_clr   (tm_dsc_sts_qinv),
        .upd_avl   (tm_dsc_sts_avl),
        .ded_en    (ded_en),
        .ded_idx   (rr_ptr),
        .ded_amt   (crd_per_pkt),
        .rd_idx    (rr_ptr),
        .rd_credit (rd_credit)
    );

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            state        <= IDLE;
            base_r       <= '0;
            nq_r         <= '0;
            rr_ptr       <= '0;
            sched_valid  <= 1'b0;
            sched_qid    <= '0;
            pkt_sent_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (enable) begin
                        state  <= SCAN;
                        base_r <= qid_base;
                        nq_r   <= eff_nq;
                        rr_ptr <= '0;
                    end
                end
                SCAN: begin
                    if (!enable) begin
                        state <= IDLE;
                    end else if (nq_r == '0 || crd_per_pkt == '0) begin
                        state <= SCAN;
                    end else if (rd_credit >= crd_per_pkt) begin
                        state       <= OFFER;
                        sched_valid <= 1'b1;
                        sched_qid   <= base_r + QID_W'(rr_ptr);
                    end else begin
                        rr_ptr <= rr_next;
                    end
                end
                OFFER: begin
                    // A pending offer is never withdrawn, even if enable drops.
                    if (sched_ready) begin
                        sched_valid  <= 1'b0;
                        pkt_sent_cnt <= pkt_sent_cnt + 32'd1;
                        rr_ptr       <= rr_next;
                        state        <= enable ? SCAN : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            tm_dsc_sts_rdy <= 1'b0;
            dsc_drop_cnt   <= '0;
        end else begin
            tm_dsc_sts_rdy <= 1'b1;
            if (upd_acc && !upd_ok && dsc_drop_cnt != 16'hFFFF) begin
                dsc_drop_cnt <= dsc_drop_cnt + 16'd1;
            end
        end
    end

    assign dbg_state = state;

endmodule
